// File: rtl/layer0_patch_streamer.sv
// Captures one 7x7 layer-0 patch from the patch extractor and streams it out
// one row per beat, tagging each row with the patch sequence number and block coordinates.
module layer0_patch_streamer #(
  parameter int PATCH_SIZE  = 7,
  parameter int NUM_PATCHES = 64,
  parameter int SIGNED_CONV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_extraction,
  input  logic [6:0][6:0][31:0] patch_data_in,
  input  logic                  patches_valid,
  input  logic                  all_channels_done,
  input  logic [5:0]            block_start_col_addr,
  input  logic [5:0]            block_start_row_addr,
  output logic                  next_spatial_block,
  output logic [55:0]           out_row_data,
  output logic [2:0]            out_row_idx,
  output logic [5:0]            out_patch_idx,
  output logic [5:0]            out_col_tag,
  output logic [5:0]            out_row_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  layer_done,
  output logic                  overflow_err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ROW   = 3'(PATCH_SIZE - 1);
  localparam logic [6:0] PATCH_LIM  = 7'(NUM_PATCHES);
  localparam logic [7:0] CONV_MASK  = (SIGNED_CONV != 0) ? 8'h80 : 8'h00;

  state_t                state_q, state_d;
  logic [6:0][6:0][7:0]  patch_q, patch_d;
  logic [2:0]            row_idx_q, row_idx_d;
  logic                  valid_q, valid_d;
  logic [5:0]            patch_idx_q, patch_idx_d;
  logic [5:0]            col_tag_q, col_tag_d;
  logic [5:0]            row_tag_q, row_tag_d;
  logic [6:0]            cnt_q, cnt_d;
  logic                  layer_done_q, layer_done_d;
  logic                  ovf_q, ovf_d;
  logic                  nsb_q, nsb_d;
  logic                  xfer;
  logic                  unused_hi;

  // Handshake: a row beat transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low every
  // out_* signal holds, and out_valid never drops without a transfer except on
  // start_extraction or reset.
  assign xfer = valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    patch_d      = patch_q;
    row_idx_d    = row_idx_q;
    valid_d      = valid_q;
    patch_idx_d  = patch_idx_q;
    col_tag_d    = col_tag_q;
    row_tag_d    = row_tag_q;
    cnt_d        = cnt_q;
    layer_done_d = layer_done_q;
    ovf_d        = ovf_q;
    nsb_d        = 1'b0;
    if (start_extraction) begin
      state_d      = IDLE;
      valid_d      = 1'b0;
      row_idx_d    = 3'd0;
      cnt_d        = 7'd0;
      layer_done_d = 1'b0;
      ovf_d        = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // The previous-cycle release guard stops a stale patch being taken twice.
          if (patches_valid && !nsb_q) begin
            for (int i = 0; i < 7; i++) begin
              for (int j = 0; j < 7; j++) begin
                patch_d[i][j] = patch_data_in[i][j][7:0] ^ CONV_MASK;
              end
            end
            col_tag_d   = block_start_col_addr;
            row_tag_d   = block_start_row_addr;
            patch_idx_d = cnt_q[5:0];
            if (cnt_q >= PATCH_LIM) ovf_d = 1'b1;
            nsb_d       = 1'b1;
            valid_d     = 1'b1;
            row_idx_d   = 3'd0;
            state_d     = STREAM;
          end else if (all_channels_done && !patches_valid) begin
            layer_done_d = 1'b1;
            state_d      = DONE;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (row_idx_q == LAST_ROW) begin
              valid_d   = 1'b0;
              row_idx_d = 3'd0;
              state_d   = IDLE;
              if (cnt_q != 7'd127) cnt_d = cnt_q + 7'd1;
            end else begin
              row_idx_d = row_idx_q + 3'd1;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      patch_q      <= '0;
      row_idx_q    <= 3'd0;
      valid_q      <= 1'b0;
      patch_idx_q  <= 6'd0;
      col_tag_q    <= 6'd0;
      row_tag_q    <= 6'd0;
      cnt_q        <= 7'd0;
      layer_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      nsb_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      patch_q      <= patch_d;
      row_idx_q    <= row_idx_d;
      valid_q      <= valid_d;
      patch_idx_q  <= patch_idx_d;
      col_tag_q    <= col_tag_d;
      row_tag_q    <= row_tag_d;
      cnt_q        <= cnt_d;
      layer_done_q <= layer_done_d;
      ovf_q        <= ovf_d;
      nsb_q        <= nsb_d;
    end
  end

  // Only the low byte of each extractor word carries pixel data.
  always_comb begin
    unused_hi = 1'b0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        unused_hi = unused_hi ^ (^patch_data_in[i][j][31:8]);
      end
    end
  end

  assign next_spatial_block = nsb_q;
  assign out_row_data       = patch_q[row_idx_q];
  assign out_row_idx        = row_idx_q;
  assign out_patch_idx      = patch_idx_q;
  assign out_col_tag        = col_tag_q;
  assign out_row_tag        = row_tag_q;
  assign out_valid          = valid_q;
  assign out_last           = valid_q && (row_idx_q == LAST_ROW);
  assign layer_done         = layer_done_q;
  assign overflow_err       = ovf_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_layer0_patch_streamer.sv
// Directed bench for layer0_patch_streamer: a row-level model predicts every
// beat from the patch contents, and a negedge compare checks the output channel.
module tb_layer0_patch_streamer;

  localparam int NP = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start_extraction;
  logic [6:0][6:0][31:0] patch_data_in;
  logic                  patches_valid;
  logic                  all_channels_done;
  logic [5:0]            block_start_col_addr;
  logic [5:0]            block_start_row_addr;
  logic                  next_spatial_block;
  logic [55:0]           out_row_data;
  logic [2:0]            out_row_idx;
  logic [5:0]            out_patch_idx;
  logic [5:0]            out_col_tag;
  logic [5:0]            out_row_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  layer_done;
  logic                  overflow_err;
  logic [1:0]            dbg_state;

  always #5 clk = ~clk;

  layer0_patch_streamer dut (
    .clk                  (clk),
    .reset                (reset),
    .start_extraction     (start_extraction),
    .patch_data_in        (patch_data_in),
    .patches_valid        (patches_valid),
    .all_channels_done    (all_channels_done),
    .block_start_col_addr (block_start_col_addr),
    .block_start_row_addr (block_start_row_addr),
    .next_spatial_block   (next_spatial_block),
    .out_row_data         (out_row_data),
    .out_row_idx          (out_row_idx),
    .out_patch_idx        (out_patch_idx),
    .out_col_tag          (out_col_tag),
    .out_row_tag          (out_row_tag),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_last             (out_last),
    .layer_done           (layer_done),
    .overflow_err         (overflow_err),
    .dbg_state            (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;
  int total_beats = 0;
  int exp_cnt     = 0;
  logic exp_ovf   = 1'b0;

  // {row data 56, row idx 3, patch idx 6, col tag 6, row tag 6}
  logic [76:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gen_byte(input int pat, input int i, input int j);
    case (pat)
      0:       return 8'(i * 7 + j);
      1:       return 8'(255 - (i * 7 + j));
      default: return 8'(i * 37 + j * 11 + pat * 5);
    endcase
  endfunction

  task automatic drive_patch(input int pat, input logic [5:0] ctag, input logic [5:0] rtag);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++)
        patch_data_in[i][j] = {8'(pat), 8'hA5, 8'(i * 8 + j), gen_byte(pat, i, j)};
    block_start_col_addr = ctag;
    block_start_row_addr = rtag;
    patches_valid        = 1'b1;
  endtask

  // uint8 -> int8 reinterpretation: value minus 128, kept as two's complement bits.
  task automatic model_capture(input int pat, input logic [5:0] ctag, input logic [5:0] rtag);
    logic [55:0] row;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 7; c++) row[8*c +: 8] = 8'(int'(gen_byte(pat, r, c)) - 128);
      exp_q.push_back({row, 3'(r), 6'(exp_cnt % 64), ctag, rtag});
    end
    if (exp_cnt >= NP) exp_ovf = 1'b1;
  endtask

  task automatic compare_step();
    logic [76:0] e;
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q[0];
        check("row_data",  64'(out_row_data),  64'(e[76:21]));
        check("row_idx",   64'(out_row_idx),   64'(e[20:18]));
        check("patch_idx", 64'(out_patch_idx), 64'(e[17:12]));
        check("col_tag",   64'(out_col_tag),   64'(e[11:6]));
        check("row_tag",   64'(out_row_tag),   64'(e[5:0]));
        check("out_last",  64'(out_last),      64'(e[20:18] == 3'd6));
        if (out_ready) begin
          void'(exp_q.pop_front());
          total_beats++;
        end
      end
    end
  endtask

  // All tasks below start and end at one time unit after a rising edge.
  task automatic capture(input int pat, input logic [5:0] ctag, input logic [5:0] rtag);
    drive_patch(pat, ctag, rtag);
    model_capture(pat, ctag, rtag);
    @(posedge clk); #1;
    patches_valid = 1'b0;
    check("nsb_pulse",    64'(next_spatial_block), 64'd1);
    check("valid_start",  64'(out_valid),          64'd1);
    check("first_row",    64'(out_row_idx),        64'd0);
    check("overflow_err", 64'(overflow_err),       64'(exp_ovf));
    check("layer_done_0", 64'(layer_done),         64'd0);
  endtask

  task automatic stream(input bit bp, input bit pin);
    logic [3:0] rp;
    int start_beats;
    rp = 4'b1001;
    start_beats = total_beats;
    for (int k = 0; k < 60; k++) begin
      if (pin && out_valid && out_row_idx == 3'd2)
        check("pin_r2c3", 64'(out_row_data[31:24]), 64'h91);
      if (pin && out_valid && out_row_idx == 3'd6) begin
        check("pin_r6c6", 64'(out_row_data[55:48]), 64'hB0);
        check("pin_last", 64'(out_last), 64'd1);
      end
      out_ready = bp ? rp[3 - (k % 4)] : 1'b1;
      @(posedge clk); #1;
      check("nsb_once", 64'(next_spatial_block), 64'd0);
      if (!out_valid) break;
    end
    check("stream_end",    64'(out_valid),                 64'd0);
    check("beat_count",    64'(total_beats - start_beats), 64'd7);
    check("queue_drained", 64'(exp_q.size()),              64'd0);
    if (exp_cnt < 127) exp_cnt++;
  endtask

  task automatic run_to_row(input logic [2:0] row);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && out_row_idx != row; k++) begin
      @(posedge clk); #1;
    end
    check("reach_row", 64'(out_row_idx), 64'(row));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start_extraction = 1'b0; patches_valid = 1'b0;
    all_channels_done = 1'b0; out_ready = 1'b1; patch_data_in = '0;
    block_start_col_addr = 6'd0; block_start_row_addr = 6'd0;
    fork
      forever begin
        @(negedge clk);
        compare_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_nsb",   64'(next_spatial_block), 64'd0);
    check("rst_last",  64'(out_last), 64'd0);
    check("rst_data",  64'(out_row_data), 64'd0);
    check("rst_ridx",  64'(out_row_idx), 64'd0);
    check("rst_pidx",  64'(out_patch_idx), 64'd0);
    check("rst_tags",  64'({out_col_tag, out_row_tag}), 64'd0);
    check("rst_done",  64'(layer_done), 64'd0);
    check("rst_ovf",   64'(overflow_err), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Ramp patch, full throughput, with literal pins on the converted bytes.
    capture(0, 6'd5, 6'd9);
    check("pin_row0", 64'(out_row_data), 64'h86_85_84_83_82_81_80);
    stream(1'b0, 1'b1);

    // Backpressure 1,0,0,1.
    capture(1, 6'd17, 6'd42);
    stream(1'b1, 1'b0);

    // start_extraction mid-stream discards the patch and clears the counter.
    capture(3, 6'd1, 6'd2);
    run_to_row(3'd2);
    start_extraction = 1'b1;
    @(posedge clk); #1;
    start_extraction = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    check("start_valid", 64'(out_valid), 64'd0);
    check("start_done",  64'(layer_done), 64'd0);
    check("start_ovf",   64'(overflow_err), 64'd0);

    // Full frame; the last capture coincides with all_channels_done.
    for (int n = 0; n < NP; n++) begin
      all_channels_done = (n == NP - 1);
      capture(2 + n, 6'(n), 6'(63 - n));
      stream(1'b0, 1'b0);
    end
    @(posedge clk); #1;
    check("frame_done", 64'(layer_done), 64'd1);
    check("frame_ovf",  64'(overflow_err), 64'd0);

    // DONE ignores further patches.
    drive_patch(1, 6'd3, 6'd3);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("done_nsb",   64'(next_spatial_block), 64'd0);
      check("done_valid", 64'(out_valid), 64'd0);
    end
    patches_valid = 1'b0;
    all_channels_done = 1'b0;

    start_extraction = 1'b1;
    @(posedge clk); #1;
    start_extraction = 1'b0;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    check("restart_done", 64'(layer_done), 64'd0);

    // 65 patches: the last one overflows and its 6-bit index wraps to 0.
    for (int n = 0; n < NP + 1; n++) begin
      capture(70 + n, 6'(n + 1), 6'(n));
      if (n == NP - 1) check("p64_ovf", 64'(overflow_err), 64'd0);
      if (n == NP) begin
        check("p65_ovf", 64'(overflow_err), 64'd1);
        check("p65_idx", 64'(out_patch_idx), 64'd0);
      end
      stream(1'b0, 1'b0);
    end

    // Reset during beat 3 of a patch with index 1.
    capture(5, 6'd7, 6'd8);
    check("p66_idx", 64'(out_patch_idx), 64'd1);
    run_to_row(3'd3);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_cnt = 0;
    exp_ovf = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pidx",  64'(out_patch_idx), 64'd0);
    check("mid_rst_ridx",  64'(out_row_idx), 64'd0);
    check("mid_rst_ovf",   64'(overflow_err), 64'd0);
    check("mid_rst_data",  64'(out_row_data), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    capture(1, 6'd11, 6'd12);
    stream(1'b1, 1'b0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
